// File: rtl/ttt_game_ctrl_if.sv
// Tic-tac-toe controller interface bundle.
// Purpose: groups the button pulses, the VGA pixel inputs and the board/pixel
//          outputs of ttt_game_ctrl so they travel as one port.
// Ports:
//   master : drives buttons and hc/vc/blank, observes board, cursor, state and draw outputs
//   slave  : the controller side (ttt_game_ctrl)
interface ttt_game_ctrl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_place;
  logic        btn_new;
  logic [10:0] hc;
  logic [10:0] vc;
  logic        blank;
  logic [8:0]  board_x;
  logic [8:0]  board_o;
  logic        turn;
  logic [3:0]  cursor;
  logic [1:0]  game_state;
  logic [10:0] cell_x;
  logic [10:0] cell_y;
  logic        draw_x;
  logic        draw_o;
  logic        draw_cursor;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, btn_new,
    output hc, vc, blank,
    input  board_x, board_o, turn, cursor, game_state,
    input  cell_x, cell_y, draw_x, draw_o, draw_cursor
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, btn_new,
    input  hc, vc, blank,
    output board_x, board_o, turn, cursor, game_state,
    output cell_x, cell_y, draw_x, draw_o, draw_cursor
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller.
// Purpose: holds the 3x3 board, cursor and turn, applies button commands,
//          detects win/draw, and maps the VGA beam position to the board cell
//          under it (registered, one cycle latency) for the sprite/cursor overlay.
// Ports:
//   clk   : pixel/system clock
//   rst_n : synchronous active-low reset
//   io    : ttt_game_ctrl_if.slave (buttons, hc/vc/blank in; board, turn,
//           cursor, game_state, cell_x/cell_y, draw_* out)
//
// state | meaning
// ------+--------------------------------------------
// PLAY  | game in progress, moves and placements accepted
// XWIN  | X completed a line; waits for btn_new
// OWIN  | O completed a line; waits for btn_new
// DRAW  | board full with no line; waits for btn_new
module ttt_game_ctrl #(
  parameter int BOARD_X0 = 0,
  parameter int BOARD_Y0 = 0,
  parameter int CELL_W   = 213,
  parameter int CELL_H   = 160
) (
  input logic           clk,
  input logic           rst_n,
  ttt_game_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_XWIN = 2'd1,
    S_OWIN = 2'd2,
    S_DRAW = 2'd3
  } state_t;

  localparam logic [31:0] L_X0 = 32'(BOARD_X0);
  localparam logic [31:0] L_X1 = 32'(BOARD_X0 + CELL_W);
  localparam logic [31:0] L_X2 = 32'(BOARD_X0 + 2 * CELL_W);
  localparam logic [31:0] L_X3 = 32'(BOARD_X0 + 3 * CELL_W);
  localparam logic [31:0] L_Y0 = 32'(BOARD_Y0);
  localparam logic [31:0] L_Y1 = 32'(BOARD_Y0 + CELL_H);
  localparam logic [31:0] L_Y2 = 32'(BOARD_Y0 + 2 * CELL_H);
  localparam logic [31:0] L_Y3 = 32'(BOARD_Y0 + 3 * CELL_H);

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_board_x, r_board_o, w_bx_nxt, w_bo_nxt;
  logic        r_turn, w_turn_nxt;
  logic [3:0]  r_cursor, w_cur_nxt;
  logic [8:0]  w_cur_oh;
  logic [8:0]  w_mover_nxt;
  logic [1:0]  w_cur_col;

  function automatic logic f_line(input logic [8:0] b);
    f_line = (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
             (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
             (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  assign w_cur_oh = 9'b1 << r_cursor;

  always_comb begin
    w_cur_col = 2'd1;
    case (r_cursor)
      4'd0, 4'd3, 4'd6: w_cur_col = 2'd0;
      4'd2, 4'd5, 4'd8: w_cur_col = 2'd2;
      default:          w_cur_col = 2'd1;
    endcase
  end

  // Next-state logic; win/draw is judged on the board after this cycle's placement.
  always_comb begin
    w_state_nxt = r_state;
    w_bx_nxt    = r_board_x;
    w_bo_nxt    = r_board_o;
    w_turn_nxt  = r_turn;
    w_cur_nxt   = r_cursor;
    w_mover_nxt = r_turn ? r_board_o : r_board_x;
    if (io.btn_new) begin
      w_state_nxt = S_PLAY;
      w_bx_nxt    = 9'd0;
      w_bo_nxt    = 9'd0;
      w_turn_nxt  = 1'b0;
      w_cur_nxt   = 4'd4;
    end else if (r_state == S_PLAY) begin
      if (io.btn_place) begin
        if (((r_board_x | r_board_o) & w_cur_oh) == 9'd0) begin
          if (r_turn) w_bo_nxt = r_board_o | w_cur_oh;
          else        w_bx_nxt = r_board_x | w_cur_oh;
          w_turn_nxt  = ~r_turn;
          w_mover_nxt = r_turn ? w_bo_nxt : w_bx_nxt;
          if (f_line(w_mover_nxt))           w_state_nxt = r_turn ? S_OWIN : S_XWIN;
          else if (&(w_bx_nxt | w_bo_nxt))   w_state_nxt = S_DRAW;
        end
      end else if (io.btn_up) begin
        w_cur_nxt = (r_cursor < 4'd3) ? r_cursor + 4'd6 : r_cursor - 4'd3;
      end else if (io.btn_down) begin
        w_cur_nxt = (r_cursor > 4'd5) ? r_cursor - 4'd6 : r_cursor + 4'd3;
      end else if (io.btn_left) begin
        w_cur_nxt = (w_cur_col == 2'd0) ? r_cursor + 4'd2 : r_cursor - 4'd1;
      end else if (io.btn_right) begin
        w_cur_nxt = (w_cur_col == 2'd2) ? r_cursor - 4'd2 : r_cursor + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_PLAY;
      r_board_x <= 9'd0;
      r_board_o <= 9'd0;
      r_turn    <= 1'b0;
      r_cursor  <= 4'd4;
    end else begin
      r_state   <= w_state_nxt;
      r_board_x <= w_bx_nxt;
      r_board_o <= w_bo_nxt;
      r_turn    <= w_turn_nxt;
      r_cursor  <= w_cur_nxt;
    end
  end

  // Pixel path: comparator-based cell lookup, no division.
  logic [31:0] w_hc, w_vc;
  logic        w_in_board;
  logic [1:0]  w_col, w_row;
  logic [10:0] w_cx, w_cy;
  logic [3:0]  w_cell_idx;
  logic [8:0]  w_cell_oh;

  assign w_hc       = {21'd0, io.hc};
  assign w_vc       = {21'd0, io.vc};
  assign w_in_board = (w_hc >= L_X0) && (w_hc < L_X3) && (w_vc >= L_Y0) && (w_vc < L_Y3);

  always_comb begin
    w_col = 2'd0;
    w_cx  = L_X0[10:0];
    if (w_hc >= L_X2) begin
      w_col = 2'd2;
      w_cx  = L_X2[10:0];
    end else if (w_hc >= L_X1) begin
      w_col = 2'd1;
      w_cx  = L_X1[10:0];
    end
    w_row = 2'd0;
    w_cy  = L_Y0[10:0];
    if (w_vc >= L_Y2) begin
      w_row = 2'd2;
      w_cy  = L_Y2[10:0];
    end else if (w_vc >= L_Y1) begin
      w_row = 2'd1;
      w_cy  = L_Y1[10:0];
    end
  end

  assign w_cell_idx = ({2'd0, w_row} * 4'd3) + {2'd0, w_col};
  assign w_cell_oh  = 9'b1 << w_cell_idx;

  logic [10:0] r_cell_x, r_cell_y;
  logic        r_draw_x, r_draw_o, r_draw_cursor;

  // Draw enables use the board registers as of this edge, so a placement
  // shows up from the following pixel onward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cell_x      <= 11'd0;
      r_cell_y      <= 11'd0;
      r_draw_x      <= 1'b0;
      r_draw_o      <= 1'b0;
      r_draw_cursor <= 1'b0;
    end else if (!io.blank && w_in_board) begin
      r_cell_x      <= w_cx;
      r_cell_y      <= w_cy;
      r_draw_x      <= |(r_board_x & w_cell_oh);
      r_draw_o      <= |(r_board_o & w_cell_oh);
      r_draw_cursor <= (w_cell_idx == r_cursor);
    end else begin
      r_draw_x      <= 1'b0;
      r_draw_o      <= 1'b0;
      r_draw_cursor <= 1'b0;
    end
  end

  assign io.board_x     = r_board_x;
  assign io.board_o     = r_board_o;
  assign io.turn        = r_turn;
  assign io.cursor      = r_cursor;
  assign io.game_state  = r_state;
  assign io.cell_x      = r_cell_x;
  assign io.cell_y      = r_cell_y;
  assign io.draw_x      = r_draw_x;
  assign io.draw_o      = r_draw_o;
  assign io.draw_cursor = r_draw_cursor;

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Game controller for the tic-tac-toe display. It holds the 3×3 board, the cursor and the current turn, and applies player moves. It detects win and draw and ends the game on either. On the pixel side it maps the VGA counters to the board cell under the beam and emits that cell's origin plus draw enables. The X/O sprite generators and the cursor overlay consume these outputs.

## Interface
Parameters:
- BOARD_X0, 0: left edge of board in pixels
- BOARD_Y0, 0: top edge of board in pixels
- CELL_W, 213: cell width in pixels
- CELL_H, 160: cell height in pixels

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- btn_up, btn_down, btn_left, btn_right  in  1 each  one-cycle pulses from debouncers
- btn_place  in  1  one-cycle pulse; place current player's mark at cursor
- btn_new  in  1  one-cycle pulse; start a new game
- hc, vc  in  11 each  current pixel coordinates
- blank  in  1  blanking interval
- board_x, board_o  out  9 each  occupancy per cell; bit i = cell i, i = 3*row + col
- turn  out  1  0 = X to move, 1 = O to move
- cursor  out  4  selected cell, 0..8
- game_state  out  2  0 PLAY, 1 XWIN, 2 OWIN, 3 DRAW
- cell_x, cell_y  out  11 each  origin of cell under (hc,vc)
- draw_x, draw_o, draw_cursor  out  1 each  cell under beam holds X / holds O / is cursor

## Operation
- Reset values:
  - board_x = board_o = 0
  - turn = 0
  - cursor = 4
  - game_state = PLAY
  - cell_x = cell_y = 0
  - draw_x = draw_o = draw_cursor = 0
- Command priority per cycle: btn_new > btn_place > moves.
  - Among moves: up > down > left > right.
  - At most one command takes effect per cycle; lower-priority pulses in the same cycle are dropped.
- btn_new: accepted in any state; clears the board, sets turn = 0, cursor = 4, game_state = PLAY.
- Moves (PLAY only; ignored otherwise) wrap within the row or column:
  - up: row 0 → row 2, else row−1
  - down: row 2 → row 0, else row+1
  - left: col 0 → col 2, else col−1
  - right: col 2 → col 0, else col+1
- btn_place in PLAY:
  - Cursor cell empty: set board_x[cursor] if turn = 0, else board_o[cursor]; toggle turn.
  - Cursor cell occupied: no effect, turn unchanged.
  - Outside PLAY: ignored.
- FSM next state is evaluated on the next-board value, in the same edge as the placement:
  - Any of the 8 lines (3 rows, 3 cols, 2 diagonals) complete for the mover → XWIN or OWIN.
  - Otherwise, all 9 cells occupied → DRAW.
  - Otherwise → stay in PLAY.
  - A win on the ninth move reports the win, not DRAW.
- XWIN, OWIN and DRAW are terminal; only btn_new or reset leaves them.
- Pixel mapping:
  - col = 0/1/2 when hc − BOARD_X0 lies in [0,CELL_W), [CELL_W,2·CELL_W), [2·CELL_W,3·CELL_W); row uses vc, BOARD_Y0 and CELL_H the same way.
  - Use comparators, no division.
  - cell_x = BOARD_X0 + col·CELL_W; cell_y = BOARD_Y0 + row·CELL_H.
  - Outside the board, or when blank = 1: draw_* = 0, and cell_x/cell_y hold their previous value.

## Timing
- Board, turn, cursor and game_state update on the clk edge that samples the command pulse; the new values are visible the next cycle.
- Pixel outputs are registered with 1-cycle latency: outputs at cycle N+1 describe (hc, vc, blank) sampled at edge N.
  - Downstream sprite logic must delay hc/vc by one cycle to match.
- draw_x/draw_o reflect the board as of the sampling edge; a mid-frame placement appears from the next pixel onward.
- rst_n low at any edge overrides all commands; the block leaves reset in PLAY with the reset values.

## Test plan
- Reset then idle: board_x = board_o = 0, turn = 0, cursor = 4, game_state = 0; pixel (hc=0, vc=0) → cell_x = 0, cell_y = 0, draw_cursor = 0.
- Moves from cursor 4: left, left → 3 then 5 (wrap); up, up → 2 then 8 (wrap); up and right pulsed together → only up applied.
- Play X@0, O@3, X@1, O@4, X@2 → board_x = 0x007, board_o = 0x018, game_state = XWIN on the edge of the fifth place; further btn_place and moves are ignored.
- Place on an occupied cell: X@4, then place at 4 again → board unchanged, turn stays 1; then btn_place and btn_new in the same cycle → cleared board, turn = 0, cursor = 4, PLAY.
- Draw game: X@0, O@1, X@2, O@4, X@3, O@5, X@7, O@6, X@8 → board_x = 0x18D, board_o = 0x072, game_state = DRAW. Separately, a ninth move that completes a line → XWIN, not DRAW.
- Pixel path, defaults, X at cell 4, cursor 4: hc = 300, vc = 200 → one cycle later cell_x = 213, cell_y = 160, draw_x = 1, draw_cursor = 1. hc = 700 → draw_* = 0. blank = 1 → draw_* = 0.
